// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: decodes the IR into datapath controls; ctrl/illegal are combinational from state+inputs.
// Memory handshakes stall on mem_ready with an 8-bit timeout into a sticky ERR; define INSTR_CNT_EN for the retired counter.
module multicycle_control #(
  parameter int INST_W      = 32,
  parameter int CTRL_W      = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              mem_ready,
  input  logic              zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        state,
  output logic              illegal,
  output logic              err,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [5:0] OP_R   = 6'b010010;
  localparam logic [5:0] OP_LW  = 6'b010011;
  localparam logic [5:0] OP_SW  = 6'b010100;
  localparam logic [5:0] OP_BEQ = 6'b010101;
  localparam logic [5:0] OP_J   = 6'b010110;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      cur, nxt;
  logic [7:0]  wait_cnt;
  logic [5:0]  opcode, funct;
  logic [3:0]  r_aluop;
  logic        r_ok, is_r, is_lw, is_sw, is_beq, is_j, legal, timeout, ill;
  logic [15:0] c;
  logic        unused_inst;

  assign opcode      = inst[INST_W-1 -: 6];
  assign funct       = inst[5:0];
  assign unused_inst = ^inst[INST_W-7:6];
  assign is_r        = (opcode == OP_R);
  assign is_lw       = (opcode == OP_LW);
  assign is_sw       = (opcode == OP_SW);
  assign is_beq      = (opcode == OP_BEQ);
  assign is_j        = (opcode == OP_J);
  assign legal       = (is_r && r_ok) || is_lw || is_sw || is_beq || is_j;
  assign timeout     = (wait_cnt == TIMEOUT) && !mem_ready;
  assign state       = cur;

  always_comb begin
    r_ok    = 1'b1;
    r_aluop = 4'b0000;
    case (funct)
      6'b100000: r_aluop = 4'b0010;
      6'b100010: r_aluop = 4'b0110;
      6'b100100: r_aluop = 4'b0000;
      6'b100101: r_aluop = 4'b0001;
      6'b101010: r_aluop = 4'b0111;
      6'b110010: r_aluop = 4'b1100;
      default:   r_ok    = 1'b0;
    endcase
  end

  // c: [0]pc_we [1]ir_we [2]mem_req [3]mem_we [4]reg_we [5]reg_dst [6]mem_to_reg [7]alu_src_a [9:8]alu_src_b [11:10]pc_src [15:12]alu_op
  always_comb begin
    nxt = cur;
    c   = '0;
    ill = 1'b0;
    case (cur)
      FETCH: begin
        c[2]     = 1'b1;
        c[9:8]   = 2'b01;
        c[15:12] = 4'b0010;
        if (mem_ready) begin
          c[1:0] = 2'b11;
          nxt    = DECODE;
        end else if (timeout) begin
          nxt = ERR;
        end
      end
      DECODE: begin
        if (!legal) begin
          ill = 1'b1;
          nxt = FETCH;
        end else if (is_j) begin
          c[0]     = 1'b1;
          c[11:10] = 2'b10;
          nxt      = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        c[7] = 1'b1;
        if (is_r) begin
          c[15:12] = r_aluop;
          nxt      = WB;
        end else if (is_beq) begin
          c[15:12] = 4'b0110;
          c[11:10] = 2'b01;
          c[0]     = zero;
          nxt      = FETCH;
        end else if (is_lw || is_sw) begin
          c[9:8]   = 2'b10;
          c[15:12] = 4'b0010;
          nxt      = MEM;
        end else begin
          nxt = FETCH;
        end
      end
      MEM: begin
        c[2] = 1'b1;
        c[3] = is_sw;
        if (mem_ready)    nxt = is_lw ? WB : FETCH;
        else if (timeout) nxt = ERR;
      end
      WB: begin
        c[4] = 1'b1;
        c[5] = is_r;
        c[6] = is_lw;
        nxt  = FETCH;
      end
      ERR:     nxt = ERR;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (!rst) ctrl[15:0] = c;
  end

  assign illegal = ill && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= FETCH;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= 8'd0;
      else if ((cur == FETCH || cur == MEM) && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (nxt == ERR) err <= 1'b1;
    end
  end

`ifdef INSTR_CNT_EN
  // Only legal completions land in FETCH from these states; DECODE->FETCH also covers illegal, hence the legal term.
  always_ff @(posedge clk) begin
    if (rst)
      retired <= 32'd0;
    else if (nxt == FETCH && (cur == WB || cur == EXEC || cur == MEM || (cur == DECODE && legal)))
      retired <= retired + 32'd1;
  end
`else
  assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction trace model predicts state/ctrl/illegal/err every cycle.
module tb_multicycle_control;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, mem_ready, zero, illegal, err;
  logic [31:0] inst, ctrl, retired;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_control #(.INST_W(32), .CTRL_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .zero(zero),
    .ctrl(ctrl), .state(state), .illegal(illegal), .err(err), .retired(retired)
  );

  typedef struct {
    logic [2:0]  st;
    logic [31:0] ctl;
    logic        ill;
    logic        rdy;
  } step_t;

  step_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_ret = 0;

  logic [5:0] ftab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110010};
  logic [3:0] atab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [2:0] st, input logic [31:0] ctl, input logic ill, input logic rdy);
    step_t s;
    s.st = st; s.ctl = ctl; s.ill = ill; s.rdy = rdy;
    q.push_back(s);
  endtask

  function automatic logic [31:0] exp_retired();
`ifdef INSTR_CNT_EN
    return exp_ret;
`else
    return 32'd0;
`endif
  endfunction

  // Expected per-cycle trace of one instruction: fw/mw are mem_ready-low cycles in FETCH/MEM.
  task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic z);
    logic [5:0] op;
    logic [3:0] aop;
    bit         fok;
    inst = ins;
    zero = z;
    op   = ins[31:26];
    fok  = 0;
    aop  = 4'd0;
    for (int i = 0; i < 6; i++)
      if (ins[5:0] == ftab[i]) begin fok = 1; aop = atab[i]; end
    for (int i = 0; i < fw && i <= TO; i++) add(3'd0, 32'h2104, 1'b0, 1'b0);
    if (fw > TO) begin add(3'd5, 32'h0, 1'b0, 1'b1); return; end
    add(3'd0, 32'h2107, 1'b0, 1'b1);
    if (!((op == 6'b010010 && fok) || (op >= 6'b010011 && op <= 6'b010110))) begin
      add(3'd1, 32'h0, 1'b1, 1'($urandom));
      return;
    end
    if (op == 6'b010110) begin
      add(3'd1, 32'h801, 1'b0, 1'($urandom));
      exp_ret++;
      return;
    end
    add(3'd1, 32'h0, 1'b0, 1'($urandom));
    case (op)
      6'b010010: begin
        add(3'd2, 32'h80 | (32'(aop) << 12), 1'b0, 1'($urandom));
        add(3'd4, 32'h30, 1'b0, 1'($urandom));
        exp_ret++;
      end
      6'b010101: begin
        add(3'd2, 32'h6480 | 32'(z), 1'b0, 1'($urandom));
        exp_ret++;
      end
      default: begin
        add(3'd2, 32'h2280, 1'b0, 1'($urandom));
        for (int i = 0; i < mw && i <= TO; i++) add(3'd3, (op == 6'b010100) ? 32'hC : 32'h4, 1'b0, 1'b0);
        if (mw > TO) begin add(3'd5, 32'h0, 1'b0, 1'b1); return; end
        add(3'd3, (op == 6'b010100) ? 32'hC : 32'h4, 1'b0, 1'b1);
        if (op == 6'b010011) add(3'd4, 32'h50, 1'b0, 1'($urandom));
        exp_ret++;
      end
    endcase
  endtask

  task automatic play(input int lim);
    step_t s;
    int    n = 0;
    while (q.size() > 0 && n < lim) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      chk("state", 32'(state), 32'(s.st));
      chk("ctrl", ctrl, s.ctl);
      chk("illegal", 32'(illegal), 32'(s.ill));
      chk("err", 32'(err), (s.st == 3'd5) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", ctrl, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
  endtask

  function automatic logic [31:0] rand_inst(input int kind);
    logic [31:0] r;
    logic [5:0]  f;
    bit          hit;
    r = $urandom;
    case (kind)
      0: r[31:26] = 6'b010010;
      1: begin
        r[31:26] = 6'b010010;
        do begin
          f = 6'($urandom);
          hit = 0;
          for (int i = 0; i < 6; i++) if (f == ftab[i]) hit = 1;
        end while (hit);
        r[5:0] = f;
      end
      2: r[31:26] = 6'b010011;
      3: r[31:26] = 6'b010100;
      4: r[31:26] = 6'b010101;
      5: r[31:26] = 6'b010110;
      default: r[31:26] = 6'($urandom);
    endcase
    if (kind == 0) r[5:0] = ftab[$urandom_range(0, 5)];
    return r;
  endfunction

  initial begin
    rst = 1'b1; inst = '0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    do_reset();

    build(32'b010010_00000_00001_00100_01010_110010, 0, 0, 1'b0); play(100);
    chk("retired_r", retired, exp_retired());
    build(32'b010011_11111_00000_0000000000000000, 0, 3, 1'b0); play(100);
    chk("retired_lw", retired, exp_retired());
    build({6'b010101, 26'h123}, 1, 0, 1'b1); play(100);
    build({6'b010101, 26'h123}, 0, 0, 1'b0); play(100);
    chk("retired_beq", retired, exp_retired());
    build({6'b111111, 26'h3FF_FFFF}, 0, 0, 1'b0); play(100);
    chk("retired_illegal", retired, exp_retired());
    build({6'b010110, 26'h0}, 2, 0, 1'b0); play(100);
    build({6'b010100, 26'h55}, 0, 2, 1'b1); play(100);
    chk("retired_j_sw", retired, exp_retired());

    for (int i = 0; i < 40; i++) begin
      build(rand_inst($urandom_range(0, 6)), $urandom_range(0, 4),
            ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 4), 1'($urandom));
      play(100);
      chk("retired_rand", retired, exp_retired());
    end

    build({6'b010011, 26'h0}, 0, 10, 1'b0); play(6);
    do_reset();
    build({6'b010010, 20'h0, 6'b100000}, 0, 0, 1'b0); play(100);
    chk("retired_after_rst", retired, exp_retired());

    build({6'b010010, 20'h0, 6'b100010}, TO, 0, 1'b0); play(100);
    build({6'b010010, 20'h0, 6'b100010}, TO + 1, 0, 1'b0);
    add(3'd5, 32'h0, 1'b0, 1'b1); add(3'd5, 32'h0, 1'b0, 1'b0); add(3'd5, 32'h0, 1'b0, 1'b1);
    play(100);
    do_reset();
    build({6'b010011, 26'h0}, 0, TO + 1, 1'b0);
    add(3'd5, 32'h0, 1'b0, 1'b1);
    play(100);
    chk("retired_err", retired, exp_retired());
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
